// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the two-player VGA paddle game.
// Owns the QI / QGAME_1 / QGAME_2 / QDONE state machine, the horizontal
// ball position, the serve hold-off, hit detection and both scores.
//
// Optional feature macro: PONG_SPEEDUP_EN
//   defined   : per-serve step register, +1 per valid hit, saturating at 2*STEP
//   undefined : constant step of STEP pixels per tick
//
// Ports:
//   clk        in   divided pixel clock
//   reset_n    in   asynchronous active-low reset
//   tick       in   one-clk movement strobe
//   start      in   start switch (level)
//   btn_p1     in   P1 button, synchronised level
//   btn_p2     in   P2 button, synchronised level
//   state      out  00 QI, 01 QGAME_1 (moving right), 10 QGAME_2 (moving left), 11 QDONE
//   ball_x     out  ball x position
//   serve_hold out  ball held at centre before serving
//   p1_score   out  P1 points
//   p2_score   out  P2 points
//   p1_win     out  P1 reached WIN_SCORE
//   p2_win     out  P2 reached WIN_SCORE
module pong_game_ctrl #(
    parameter int unsigned X_MIN       = 16,
    parameter int unsigned X_MAX       = 624,
    parameter int unsigned X_MID       = 320,
    parameter int unsigned STEP        = 4,
    parameter int unsigned HIT_WIN     = 32,
    parameter int unsigned SERVE_TICKS = 8,
    parameter int unsigned WIN_SCORE   = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_p1,
    input  logic       btn_p2,
    output logic [1:0] state,
    output logic [9:0] ball_x,
    output logic       serve_hold,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       p1_win,
    output logic       p2_win
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [9:0] XMIN_C   = 10'(X_MIN);
    localparam logic [9:0] XMAX_C   = 10'(X_MAX);
    localparam logic [9:0] XMID_C   = 10'(X_MID);
    localparam logic [9:0] HIT_HI   = 10'(X_MAX - HIT_WIN);
    localparam logic [9:0] HIT_LO   = 10'(X_MIN + HIT_WIN);
    localparam logic [3:0] STEP_C   = 4'(STEP);
    localparam logic [3:0] SERVE_C  = 4'(SERVE_TICKS);
    localparam logic [3:0] WIN_C    = 4'(WIN_SCORE);

    state_t      st_q;
    logic        btn_p1_q, btn_p2_q;
    logic        press_p1, press_p2;
    logic        hit_p1, hit_p2;
    logic [3:0]  serve_cnt;
    logic [3:0]  step_w;
    logic [10:0] sum_r;
    logic [9:0]  x_right, x_left;

`ifdef PONG_SPEEDUP_EN
    localparam logic [3:0] STEP_MAX = 4'(2 * STEP);
    logic [3:0] step_q;
    assign step_w = step_q;
`else
    assign step_w = STEP_C;
`endif

    assign state = st_q;

    always_comb begin
        press_p1 = btn_p1 & ~btn_p1_q;
        press_p2 = btn_p2 & ~btn_p2_q;
        // Only the player the ball is travelling toward can return it.
        hit_p2   = (st_q == QGAME_1) && !serve_hold && press_p2 && (ball_x >= HIT_HI);
        hit_p1   = (st_q == QGAME_2) && !serve_hold && press_p1 && (ball_x <= HIT_LO);
        // Saturating moves; the 11-bit sum keeps the right edge from wrapping.
        sum_r    = {1'b0, ball_x} + {7'b0, step_w};
        x_right  = (sum_r >= {1'b0, XMAX_C}) ? XMAX_C : sum_r[9:0];
        x_left   = (ball_x <= XMIN_C + {6'b0, step_w}) ? XMIN_C : ball_x - {6'b0, step_w};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= QI;
            ball_x     <= XMID_C;
            serve_hold <= 1'b0;
            serve_cnt  <= '0;
            p1_score   <= '0;
            p2_score   <= '0;
            p1_win     <= 1'b0;
            p2_win     <= 1'b0;
            btn_p1_q   <= 1'b0;
            btn_p2_q   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
            step_q     <= STEP_C;
`endif
        end else begin
            btn_p1_q <= btn_p1;
            btn_p2_q <= btn_p2;
            case (st_q)
                QI: begin
                    ball_x     <= XMID_C;
                    serve_hold <= 1'b0;
                    if (start && tick) begin
                        st_q       <= QGAME_1;
                        p1_score   <= '0;
                        p2_score   <= '0;
                        p1_win     <= 1'b0;
                        p2_win     <= 1'b0;
                        serve_hold <= 1'b1;
                        serve_cnt  <= SERVE_C;
`ifdef PONG_SPEEDUP_EN
                        step_q     <= STEP_C;
`endif
                    end
                end
                QGAME_1, QGAME_2: begin
                    if (!start) begin
                        st_q       <= QI;
                        ball_x     <= XMID_C;
                        serve_hold <= 1'b0;
                    end else if (serve_hold) begin
                        if (tick) begin
                            serve_cnt <= (serve_cnt == '0) ? '0 : serve_cnt - 4'd1;
                            if (serve_cnt <= 4'd1)
                                serve_hold <= 1'b0;
                        end
                    end else if (hit_p1 || hit_p2) begin
                        // A valid hit outranks a same-clk scoring tick.
                        st_q <= hit_p2 ? QGAME_2 : QGAME_1;
`ifdef PONG_SPEEDUP_EN
                        if (step_q < STEP_MAX)
                            step_q <= step_q + 4'd1;
`endif
                    end else if (tick) begin
                        if (st_q == QGAME_1 && ball_x == XMAX_C) begin
                            p1_score <= p1_score + 4'd1;
                            ball_x   <= XMID_C;
                            if (p1_score + 4'd1 == WIN_C) begin
                                st_q   <= QDONE;
                                p1_win <= 1'b1;
                            end else begin
                                st_q       <= QGAME_2;
                                serve_hold <= 1'b1;
                                serve_cnt  <= SERVE_C;
`ifdef PONG_SPEEDUP_EN
                                step_q     <= STEP_C;
`endif
                            end
                        end else if (st_q == QGAME_2 && ball_x == XMIN_C) begin
                            p2_score <= p2_score + 4'd1;
                            ball_x   <= XMID_C;
                            if (p2_score + 4'd1 == WIN_C) begin
                                st_q   <= QDONE;
                                p2_win <= 1'b1;
                            end else begin
                                st_q       <= QGAME_1;
                                serve_hold <= 1'b1;
                                serve_cnt  <= SERVE_C;
`ifdef PONG_SPEEDUP_EN
                                step_q     <= STEP_C;
`endif
                            end
                        end else begin
                            ball_x <= (st_q == QGAME_1) ? x_right : x_left;
                        end
                    end
                end
                default: begin
                    // QDONE: result frozen until start drops; wins survive into QI.
                    ball_x     <= XMID_C;
                    serve_hold <= 1'b0;
                    if (!start)
                        st_q <= QI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, hand-written
// rally/game-end/reset sequences, and randomized play against a game model.
module tb_pong_game_ctrl;

    localparam int X_MIN       = 16;
    localparam int X_MAX       = 624;
    localparam int X_MID       = 320;
    localparam int STEP        = 4;
    localparam int HIT_WIN     = 32;
    localparam int SERVE_TICKS = 8;
    localparam int WIN_SCORE   = 10;

    logic       clk = 1'b0;
    logic       reset_n, tick, start, btn_p1, btn_p2;
    logic [1:0] state;
    logic [9:0] ball_x;
    logic       serve_hold;
    logic [3:0] p1_score, p2_score;
    logic       p1_win, p2_win;

    int n_tests = 0;
    int n_fail  = 0;

    pong_game_ctrl #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .X_MID(X_MID), .STEP(STEP),
        .HIT_WIN(HIT_WIN), .SERVE_TICKS(SERVE_TICKS), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start),
        .btn_p1(btn_p1), .btn_p2(btn_p2), .state(state), .ball_x(ball_x),
        .serve_hold(serve_hold), .p1_score(p1_score), .p2_score(p2_score),
        .p1_win(p1_win), .p2_win(p2_win)
    );

    always #5 clk = ~clk;

    // Game model: phase 0 idle, 1 playing, 2 finished; dir +1 toward P2, -1 toward P1.
    int m_phase, m_dir, m_ball, m_hold, m_cnt, m_p1, m_p2, m_w1, m_w2;
    int m_prev1, m_prev2, m_step;

    function automatic int model_state_code();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 3;
        return (m_dir > 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dir = 1; m_ball = X_MID; m_hold = 0; m_cnt = 0;
        m_p1 = 0; m_p2 = 0; m_w1 = 0; m_w2 = 0; m_prev1 = 0; m_prev2 = 0; m_step = STEP;
    endtask

    task automatic serve(input int dir);
        m_ball = X_MID; m_hold = 1; m_cnt = SERVE_TICKS; m_dir = dir; m_step = STEP;
    endtask

    task automatic award(input int who);
        if (who == 1) begin
            m_p1++;
            if (m_p1 == WIN_SCORE) begin m_phase = 2; m_w1 = 1; m_ball = X_MID; m_hold = 0; end
            else serve(-1);
        end else begin
            m_p2++;
            if (m_p2 == WIN_SCORE) begin m_phase = 2; m_w2 = 1; m_ball = X_MID; m_hold = 0; end
            else serve(1);
        end
    endtask

    task automatic model_step(input bit tk, input bit st, input bit b1, input bit b2);
        bit pr1, pr2, hit;
        pr1 = b1 && (m_prev1 == 0);
        pr2 = b2 && (m_prev2 == 0);
        m_prev1 = b1; m_prev2 = b2;
        if (m_phase == 0) begin
            m_ball = X_MID; m_hold = 0;
            if (st && tk) begin
                m_p1 = 0; m_p2 = 0; m_w1 = 0; m_w2 = 0; m_phase = 1; serve(1);
            end
        end else if (m_phase == 1) begin
            if (!st) begin
                m_phase = 0; m_ball = X_MID; m_hold = 0;
            end else if (m_hold != 0) begin
                if (tk) begin
                    m_cnt--;
                    if (m_cnt <= 0) begin m_cnt = 0; m_hold = 0; end
                end
            end else begin
                hit = (m_dir > 0) ? (pr2 && m_ball >= X_MAX - HIT_WIN)
                                  : (pr1 && m_ball <= X_MIN + HIT_WIN);
                if (hit) begin
                    m_dir = -m_dir;
`ifdef PONG_SPEEDUP_EN
                    m_step = (m_step + 1 > 2 * STEP) ? 2 * STEP : m_step + 1;
`endif
                end else if (tk) begin
                    if (m_dir > 0 && m_ball == X_MAX)      award(1);
                    else if (m_dir < 0 && m_ball == X_MIN) award(2);
                    else if (m_dir > 0) m_ball = (m_ball + m_step > X_MAX) ? X_MAX : m_ball + m_step;
                    else                m_ball = (m_ball - m_step < X_MIN) ? X_MIN : m_ball - m_step;
                end
            end
        end else begin
            m_ball = X_MID; m_hold = 0;
            if (!st) m_phase = 0;
        end
    endtask

    task automatic check(input string name, input int es, input int eb, input int eh,
                         input int e1, input int e2, input int ew1, input int ew2);
        n_tests++;
        if (state !== 2'(es) || ball_x !== 10'(eb) || serve_hold !== 1'(eh) ||
            p1_score !== 4'(e1) || p2_score !== 4'(e2) || p1_win !== 1'(ew1) || p2_win !== 1'(ew2)) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d x=%0d hold=%0d p1=%0d p2=%0d w1=%0d w2=%0d, want st=%0d x=%0d hold=%0d p1=%0d p2=%0d w1=%0d w2=%0d",
                     name, $time, state, ball_x, serve_hold, p1_score, p2_score, p1_win, p2_win,
                     es, eb, eh, e1, e2, ew1, ew2);
        end
    endtask

    task automatic cyc(input bit tk, input bit st, input bit b1, input bit b2);
        tick = tk; start = st; btn_p1 = b1; btn_p2 = b2;
        @(posedge clk);
        model_step(tk, st, b1, b2);
        #1;
        check("model", model_state_code(), m_ball, m_hold, m_p1, m_p2, m_w1, m_w2);
    endtask

    // P2 returns every ball, P1 never does: P2 wins each rally.
    // mode 0: stop with P2 on 9 and the ball sitting on X_MIN.
    // mode 1: stop with P2 >= 2 and the ball moving right past x=500.
    task automatic rally(input int mode);
        bit b2 = 1'b0;
        bit ok = 1'b0;
        for (int g = 0; g < 20000; g++) begin
            if (mode == 0 && m_p2 == 9 && m_phase == 1 && m_dir < 0 && m_ball == X_MIN) begin ok = 1'b1; break; end
            if (mode == 1 && m_p2 >= 2 && m_phase == 1 && m_dir > 0 && m_hold == 0 && m_ball >= 500) begin ok = 1'b1; break; end
            b2 = (m_phase == 1 && m_dir > 0 && m_hold == 0 && m_ball >= X_MAX - HIT_WIN + 4 && !b2);
            cyc(1'b1, 1'b1, 1'b0, b2);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rally%0d: got no target position within budget, want target reached", mode);
        end
    endtask

    typedef struct {
        int n;
        bit tk, st, b1, b2;
        int e_state, e_ball, e_hold, e_p1, e_p2;
    } vec_t;

    initial begin
        vec_t tbl[24];
        bit s_lvl, rb1, rb2;

        tbl[0]  = '{1,   1, 1, 0, 0, 1, 320, 1, 0, 0};  // start on tick
        tbl[1]  = '{7,   1, 1, 0, 0, 1, 320, 1, 0, 0};  // still holding
        tbl[2]  = '{1,   1, 1, 0, 0, 1, 320, 0, 0, 0};  // 8th tick clears hold
        tbl[3]  = '{1,   1, 1, 0, 0, 1, 324, 0, 0, 0};  // first move
        tbl[4]  = '{75,  1, 1, 0, 0, 1, 624, 0, 0, 0};
        tbl[5]  = '{1,   1, 1, 0, 0, 2, 320, 1, 1, 0};  // P1 scores, serve left
        tbl[6]  = '{8,   1, 1, 0, 0, 2, 320, 0, 1, 0};
        tbl[7]  = '{76,  1, 1, 0, 0, 2, 16,  0, 1, 0};
        tbl[8]  = '{1,   1, 1, 0, 0, 1, 320, 1, 1, 1};  // P2 scores, serve right
        tbl[9]  = '{8,   1, 1, 0, 0, 1, 320, 0, 1, 1};
        tbl[10] = '{67,  1, 1, 0, 0, 1, 588, 0, 1, 1};
        tbl[11] = '{1,   0, 1, 0, 1, 1, 588, 0, 1, 1};  // press outside window
        tbl[12] = '{1,   0, 1, 0, 0, 1, 588, 0, 1, 1};
        tbl[13] = '{1,   1, 1, 0, 0, 1, 592, 0, 1, 1};
        tbl[14] = '{1,   0, 1, 0, 1, 2, 592, 0, 1, 1};  // press on window edge
        tbl[15] = '{1,   1, 1, 0, 0, 2, 588, 0, 1, 1};
        tbl[16] = '{135, 1, 1, 0, 0, 2, 48,  0, 1, 1};
        tbl[17] = '{1,   0, 1, 1, 0, 1, 48,  0, 1, 1};  // P1 hit on window edge
        tbl[18] = '{1,   1, 1, 0, 0, 1, 52,  0, 1, 1};
        tbl[19] = '{143, 1, 1, 0, 0, 1, 624, 0, 1, 1};
        tbl[20] = '{1,   1, 1, 0, 1, 2, 624, 0, 1, 1};  // hit and scoring tick together
        tbl[21] = '{1,   1, 1, 0, 0, 2, 620, 0, 1, 1};
        tbl[22] = '{105, 1, 1, 0, 0, 2, 200, 0, 1, 1};
        tbl[23] = '{1,   0, 0, 0, 0, 0, 320, 0, 1, 1};  // abort keeps scores

        reset_n = 1'b0; tick = 1'b0; start = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset", 0, X_MID, 0, 0, 0, 0, 0);

`ifndef PONG_SPEEDUP_EN
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                cyc(tbl[i].tk, tbl[i].st, tbl[i].b1, tbl[i].b2);
            check($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_ball, tbl[i].e_hold,
                  tbl[i].e_p1, tbl[i].e_p2, 0, 0);
        end
`endif

        // Game end by P2 and win-flag persistence.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_clears", 1, X_MID, 1, 0, 0, 0, 0);
        rally(0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("p2_wins", 3, X_MID, 0, 0, 10, 0, 1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("done_ignores_tick", 3, X_MID, 0, 0, 10, 0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("done_to_idle", 0, X_MID, 0, 0, 10, 0, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("restart", 1, X_MID, 1, 0, 0, 0, 0);

        // Asynchronous reset mid-game, checked before the next clock edge.
        rally(1);
        tick = 1'b0; start = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_reset", 0, X_MID, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized play, buttons biased toward the wall the ball approaches.
        s_lvl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (s_lvl) begin
                if ($urandom_range(0, 299) == 0) s_lvl = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                s_lvl = 1'b1;
            end
            rb1 = ($urandom_range(0, 15) == 0) || (m_ball <= X_MIN + HIT_WIN + 8 && $urandom_range(0, 1) == 1);
            rb2 = ($urandom_range(0, 15) == 0) || (m_ball >= X_MAX - HIT_WIN - 8 && $urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 2) == 0, s_lvl, rb1, rb2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
